// File: rtl/atk16_mem_pkg.sv
// Shared definitions for the ATK16 memory initiator: state encoding, default sizes
// and the timeout counter width helper.
package atk16_mem_pkg;

    localparam int unsigned ADDR_W_DEFAULT         = 16;
    localparam int unsigned DATA_W_DEFAULT         = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Bits needed to hold a count from 0 up to max_count inclusive.
    function automatic int unsigned count_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One-entry request buffer {write, addr, wdata}: load fills it, take empties it.
module mem_req_slot
    import atk16_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              take,
    input  logic              new_write,
    input  logic [ADDR_W-1:0] new_addr,
    input  logic [DATA_W-1:0] new_wdata,
    output logic              valid,
    output logic              held_write,
    output logic [ADDR_W-1:0] held_addr,
    output logic [DATA_W-1:0] held_wdata
);

    // load is only possible while empty and take only while full, so they never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= 1'b0;
            held_write <= 1'b0;
            held_addr  <= '0;
            held_wdata <= '0;
        end else if (load) begin
            valid      <= 1'b1;
            held_write <= new_write;
            held_addr  <= new_addr;
            held_wdata <= new_wdata;
        end else if (take) begin
            valid      <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_master.sv
// Initiator for the level-handshake memory protocol of mem_fsm, fed by a valid/ready
// CPU port with a one-entry pending slot. Define MEM_TIMEOUT_EN to abort stuck accesses.
module mem_master
    import atk16_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W         = DATA_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_done
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("mem_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state;
    logic              accept;
    logic              slot_valid;
    logic              slot_write;
    logic [ADDR_W-1:0] slot_addr;
    logic [DATA_W-1:0] slot_wdata;
    logic              slot_load;
    logic              slot_take;
    logic              start;
    logic              next_write;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_wdata;

    assign req_ready = !slot_valid;
    assign accept    = req_valid && req_ready;
    assign slot_load = accept && (state != IDLE);

    mem_req_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (slot_load),
        .take       (slot_take),
        .new_write  (req_write),
        .new_addr   (req_addr),
        .new_wdata  (req_wdata),
        .valid      (slot_valid),
        .held_write (slot_write),
        .held_addr  (slot_addr),
        .held_wdata (slot_wdata)
    );

    // Decide when a new access starts and whether it comes from the slot or the port.
    // A request parked while RELEASE fell back to IDLE is picked up from IDLE.
    always_comb begin
        start     = 1'b0;
        slot_take = 1'b0;
        case (state)
            IDLE: begin
                start     = accept || slot_valid;
                slot_take = !accept && slot_valid;
            end
            RELEASE: begin
                start     = !mem_done && slot_valid;
                slot_take = !mem_done && slot_valid;
            end
            default: begin
                start     = 1'b0;
                slot_take = 1'b0;
            end
        endcase
    end

    assign next_write = slot_take ? slot_write : req_write;
    assign next_addr  = slot_take ? slot_addr  : req_addr;
    assign next_wdata = slot_take ? slot_wdata : req_wdata;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = count_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] access_cycles;
    logic             timeout_hit;

    assign timeout_hit = (access_cycles + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);

    // Counts ACCESS cycles of the current transfer.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            access_cycles <= '0;
        end else if (state == ACCESS) begin
            access_cycles <= access_cycles + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
`ifdef MEM_TIMEOUT_EN
            rsp_error    <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            if (start) begin
                state        <= ACCESS;
                mem_addr     <= next_addr;
                mem_data_in  <= next_wdata;
                mem_write_en <= next_write;
                mem_read_en  <= !next_write;
            end else begin
                case (state)
                    ACCESS: begin
                        if (mem_done) begin
                            mem_read_en  <= 1'b0;
                            mem_write_en <= 1'b0;
                            rsp_valid    <= 1'b1;
                            rsp_rdata    <= mem_write_en ? DATA_W'(0) : mem_data_out;
                            state        <= RELEASE;
`ifdef MEM_TIMEOUT_EN
                            rsp_error    <= 1'b0;
                        end else if (timeout_hit) begin
                            mem_read_en  <= 1'b0;
                            mem_write_en <= 1'b0;
                            rsp_valid    <= 1'b1;
                            rsp_rdata    <= '0;
                            rsp_error    <= 1'b1;
                            state        <= RELEASE;
`endif
                        end
                    end
                    RELEASE: begin
                        if (!mem_done) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifndef MEM_TIMEOUT_EN
    assign rsp_error = 1'b0;
`endif

endmodule
